// File: rtl/noc_pkg.sv
// Shared definitions for the clocked mesh router: port indices,
// dimension-ordered route decode and round-robin pick.
package noc_pkg;

    localparam int NPORT   = 5;
    localparam int P_N     = 0;
    localparam int P_E     = 1;
    localparam int P_S     = 2;
    localparam int P_W     = 3;
    localparam int P_L     = 4;
    localparam int HOP_MAX = 8;

    typedef logic [2:0] port_t;

    typedef struct packed {
        logic  found;
        port_t idx;
    } pick_t;

    // X first, then Y, else deliver locally
    function automatic port_t route_port(
        input logic               dir_x,
        input logic               dir_y,
        input logic [HOP_MAX-1:0] x_hop,
        input logic [HOP_MAX-1:0] y_hop
    );
        if (x_hop != '0)
            return dir_x ? port_t'(P_W) : port_t'(P_E);
        if (y_hop != '0)
            return dir_y ? port_t'(P_S) : port_t'(P_N);
        return port_t'(P_L);
    endfunction

    // first requester at or after ptr; descending scan keeps the nearest
    function automatic pick_t rr_pick(
        input logic [NPORT-1:0] req,
        input port_t            ptr
    );
        pick_t r;
        int    j;
        r = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NPORT;
            if (req[j]) begin
                r.found = 1'b1;
                r.idx   = port_t'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Input buffer: sync FIFO with registered ready; a freshly written
// entry becomes readable one cycle after its push.
module noc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         ready,
    output logic         avail,
    output logic [W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          pushed_q, pushed_d;

    always_comb begin
        wr_d     = wr_q + AW'(push);
        rd_d     = rd_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ready_d  = (cnt_d != (AW+1)'(DEPTH));
        pushed_d = push;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            pushed_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            pushed_q <= pushed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= din;
    end

    assign ready = ready_q;
    assign avail = (cnt_q > (AW+1)'(pushed_q));
    assign dout  = mem_q[rd_q];

endmodule

// File: rtl/noc_router_sync.sv
// Single-flit 5-port mesh node: buffered inputs, XY routing,
// round-robin arbitration into registered valid/ready outputs.
module noc_router_sync
    import noc_pkg::*;
#(
    parameter  int PAYLOAD_W = 32,
    parameter  int XHW       = 3,
    parameter  int YHW       = 3,
    parameter  int DEPTH     = 4,
    localparam int FLIT_W    = 2 + XHW + YHW + PAYLOAD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        in_valid,
    output logic [NPORT-1:0]        in_ready,
    input  logic [NPORT*FLIT_W-1:0] in_data,
    output logic [NPORT-1:0]        out_valid,
    input  logic [NPORT-1:0]        out_ready,
    output logic [NPORT*FLIT_W-1:0] out_data,
    output logic                    err_uturn
);

    localparam int YLSB = PAYLOAD_W;
    localparam int XLSB = PAYLOAD_W + YHW;

    logic [FLIT_W-1:0] head [NPORT];
    logic [FLIT_W-1:0] fwd  [NPORT];
    port_t             route [NPORT];
    logic [NPORT-1:0]  avail, pop, uturn;
    logic [NPORT-1:0]  req [NPORT];
    pick_t             pick [NPORT];
    logic [NPORT-1:0]  load, grant;

    logic [NPORT-1:0]  ov_q, ov_d;
    logic [FLIT_W-1:0] od_q [NPORT];
    logic [FLIT_W-1:0] od_d [NPORT];
    port_t             rr_q [NPORT];
    port_t             rr_d [NPORT];
    logic              err_q, err_d;

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        noc_fifo #(
            .W     (FLIT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_valid[g] && in_ready[g]),
            .din   (in_data[g*FLIT_W +: FLIT_W]),
            .pop   (pop[g]),
            .ready (in_ready[g]),
            .avail (avail[g]),
            .dout  (head[g])
        );
        assign out_data[g*FLIT_W +: FLIT_W] = od_q[g];
    end

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            route[i] = route_port(head[i][FLIT_W-1], head[i][FLIT_W-2],
                                  HOP_MAX'(head[i][XLSB +: XHW]),
                                  HOP_MAX'(head[i][YLSB +: YHW]));
            fwd[i] = head[i];
            if (head[i][XLSB +: XHW] != '0)
                fwd[i][XLSB +: XHW] = head[i][XLSB +: XHW] >> 1;
            else if (head[i][YLSB +: YHW] != '0)
                fwd[i][YLSB +: YHW] = head[i][YLSB +: YHW] >> 1;
            uturn[i] = avail[i] && (route[i] == port_t'(i));
        end
    end

    // U-turn heads are discarded without ever requesting an output
    always_comb begin
        pop = uturn;
        for (int p = 0; p < NPORT; p++) begin
            for (int i = 0; i < NPORT; i++)
                req[p][i] = avail[i] && !uturn[i] && (route[i] == port_t'(p));
            load[p]  = !ov_q[p] || out_ready[p];
            pick[p]  = rr_pick(req[p], rr_q[p]);
            grant[p] = load[p] && pick[p].found;
            if (grant[p])
                pop[pick[p].idx] = 1'b1;
        end
    end

    always_comb begin
        ov_d  = ov_q;
        od_d  = od_q;
        rr_d  = rr_q;
        err_d = err_q || (uturn != '0);
        for (int p = 0; p < NPORT; p++) begin
            if (load[p])
                ov_d[p] = grant[p];
            if (grant[p]) begin
                od_d[p] = fwd[pick[p].idx];
                rr_d[p] = (pick[p].idx == port_t'(P_L)) ? '0 : pick[p].idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q  <= '0;
            od_q  <= '{default: '0};
            rr_q  <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            ov_q  <= ov_d;
            od_q  <= od_d;
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    assign out_valid = ov_q;
    assign err_uturn = err_q;

endmodule

// File: tb/tb_noc_router_sync.sv
// Bench for noc_router_sync: directed vector table, arbitration,
// backpressure, U-turn and reset sequences, then random traffic.
module tb_noc_router_sync;

    localparam int FW = 40;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [4:0]      in_valid, in_ready, out_valid, out_ready;
    logic [5*FW-1:0] in_data, out_data;
    logic            err_uturn;
    int              nvec = 0;
    int              nerr = 0;

    typedef struct {
        int            port;
        logic [FW-1:0] flit;
        int            dport;
        logic [FW-1:0] eflit;
    } vec_t;

    typedef struct {
        int            src;
        int            dst;
        logic [FW-1:0] f;
    } exp_t;

    noc_router_sync dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_uturn (err_uturn)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic dx, input logic dy,
                                         input logic [2:0] xh, input logic [2:0] yh,
                                         input logic [31:0] pl);
        return {dx, dy, xh, yh, pl};
    endfunction

    function automatic int hcount(input logic [2:0] h);
        int n = 0;
        for (int b = 0; b < 3; b++)
            if (h[b]) n++;
        return n;
    endfunction

    function automatic logic [2:0] therm(input int n);
        return 3'((1 << n) - 1);
    endfunction

    function automatic int exp_dst(input logic [FW-1:0] f);
        if (hcount(f[37:35]) > 0) return f[39] ? 3 : 1;
        if (hcount(f[34:32]) > 0) return f[38] ? 2 : 0;
        return 4;
    endfunction

    function automatic logic [FW-1:0] exp_flit(input logic [FW-1:0] f);
        logic [FW-1:0] o = f;
        int xn = hcount(f[37:35]);
        int yn = hcount(f[34:32]);
        if (xn > 0) o[37:35] = therm(xn - 1);
        else if (yn > 0) o[34:32] = therm(yn - 1);
        return o;
    endfunction

    function automatic logic [FW-1:0] gen(input int src, input int seq);
        logic [FW-1:0] f;
        do begin
            f = mk(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   therm(int'($urandom_range(3, 0))), therm(int'($urandom_range(3, 0))),
                   {3'(src), 29'(seq)});
        end while (exp_dst(f) == src);
        return f;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_err", 64'(err_uturn), 0);
        chk("rst_out_data_zero", 64'(out_data != '0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_held", 64'(in_ready), 0);
        tick();
        chk("rst_ready_rise", 64'(in_ready), 64'h1F);
    endtask

    task automatic run_vec(input vec_t v);
        in_valid = '0;
        in_valid[v.port] = 1'b1;
        in_data[v.port*FW +: FW] = v.flit;
        chk("vec_in_ready", 64'(in_ready[v.port]), 1);
        tick();
        in_valid = '0;
        tick();
        chk("vec_not_early", 64'(out_valid), 0);
        tick();
        chk("vec_out_port", 64'(out_valid), 64'(5'b1 << v.dport));
        chk("vec_out_data", 64'(out_data[v.dport*FW +: FW]), 64'(v.eflit));
        tick();
        chk("vec_drained", 64'(out_valid), 0);
    endtask

    task automatic fill_e(input int ncyc, output int sent);
        sent = 0;
        out_ready[1] = 1'b0;
        in_valid[4] = 1'b1;
        in_data[4*FW +: FW] = mk(0, 0, 3'b001, 3'b000, 32'hA0);
        for (int c = 0; c < ncyc; c++) begin
            if (in_valid[4] && in_ready[4]) sent++;
            tick();
            in_data[4*FW +: FW] = mk(0, 0, 3'b001, 3'b000, 32'hA0 + sent);
            if (sent >= 6) in_valid[4] = 1'b0;
        end
    endtask

    task automatic rand_phase();
        exp_t          expq[$];
        logic [FW-1:0] offer [5];
        bit            has_off [5];
        bit            prev_hold [5];
        logic [FW-1:0] prev_d [5];
        logic [FW-1:0] od;
        exp_t          e;
        int            seq, k;
        seq = 0;
        for (int i = 0; i < 5; i++) begin
            has_off[i] = 0;
            prev_hold[i] = 0;
            offer[i] = '0;
            prev_d[i] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (!has_off[i] && c < 500 && $urandom_range(1, 0) == 1) begin
                    offer[i] = gen(i, seq);
                    seq++;
                    has_off[i] = 1;
                end
                in_valid[i] = has_off[i];
                in_data[i*FW +: FW] = offer[i];
                out_ready[i] = (c >= 500) ? 1'b1 : ($urandom_range(9, 0) < 7);
            end
            for (int p = 0; p < 5; p++) begin
                od = out_data[p*FW +: FW];
                if (prev_hold[p])
                    chk("rand_hold", {23'b0, out_valid[p], od}, {23'b0, 1'b1, prev_d[p]});
                if (out_valid[p] && out_ready[p]) begin
                    k = -1;
                    for (int j = 0; j < expq.size(); j++)
                        if (k < 0 && expq[j].src == int'(od[31:29]) && expq[j].dst == p)
                            k = j;
                    chk("rand_route", 64'(k >= 0), 1);
                    if (k >= 0) begin
                        chk("rand_data", 64'(od), 64'(expq[k].f));
                        expq.delete(k);
                    end
                end
                prev_hold[p] = out_valid[p] && !out_ready[p];
                prev_d[p] = od;
            end
            for (int i = 0; i < 5; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    e.src = i;
                    e.dst = exp_dst(offer[i]);
                    e.f = exp_flit(offer[i]);
                    expq.push_back(e);
                    has_off[i] = 0;
                end
            end
            tick();
        end
        in_valid = '0;
        chk("rand_all_delivered", 64'(expq.size()), 0);
        chk("rand_no_uturn_err", 64'(err_uturn), 0);
    endtask

    initial begin
        vec_t tbl [8];
        int   sent, got;

        tbl[0] = '{4, mk(0, 0, 3'b011, 3'b000, 32'hDEADBEEF), 1, mk(0, 0, 3'b001, 3'b000, 32'hDEADBEEF)};
        tbl[1] = '{3, mk(0, 0, 3'b000, 3'b001, 32'h1), 0, mk(0, 0, 3'b000, 3'b000, 32'h1)};
        tbl[2] = '{2, mk(0, 0, 3'b000, 3'b000, 32'h22), 4, mk(0, 0, 3'b000, 3'b000, 32'h22)};
        tbl[3] = '{0, mk(1, 0, 3'b001, 3'b011, 32'h33), 3, mk(1, 0, 3'b000, 3'b011, 32'h33)};
        tbl[4] = '{1, mk(0, 1, 3'b000, 3'b111, 32'h44), 2, mk(0, 1, 3'b000, 3'b011, 32'h44)};
        tbl[5] = '{4, mk(1, 1, 3'b111, 3'b111, 32'h55), 3, mk(1, 1, 3'b011, 3'b111, 32'h55)};
        tbl[6] = '{0, mk(0, 1, 3'b000, 3'b011, 32'h66), 2, mk(0, 1, 3'b000, 3'b001, 32'h66)};
        tbl[7] = '{3, mk(0, 1, 3'b001, 3'b001, 32'h77), 1, mk(0, 1, 3'b000, 3'b001, 32'h77)};

        in_valid = '0;
        out_ready = '1;
        in_data = '0;
        do_reset();

        for (int v = 0; v < 8; v++)
            run_vec(tbl[v]);
        chk("vec_no_err", 64'(err_uturn), 0);

        // three inputs to L at once, fresh pointer
        do_reset();
        in_data[0*FW +: FW] = mk(0, 0, 0, 0, 32'h100);
        in_data[2*FW +: FW] = mk(0, 0, 0, 0, 32'h200);
        in_data[3*FW +: FW] = mk(0, 0, 0, 0, 32'h300);
        in_valid = 5'b01101;
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("rr_first_n", 64'(out_data[4*FW +: FW]), 64'(mk(0, 0, 0, 0, 32'h100)));
        chk("rr_first_valid", 64'(out_valid), 64'h10);
        tick();
        chk("rr_second_s", 64'(out_data[4*FW +: FW]), 64'(mk(0, 0, 0, 0, 32'h200)));
        tick();
        chk("rr_third_w", 64'(out_data[4*FW +: FW]), 64'(mk(0, 0, 0, 0, 32'h300)));
        tick();
        chk("rr_done", 64'(out_valid), 0);
        // pointer now 4: N beats W
        in_data[0*FW +: FW] = mk(0, 0, 0, 0, 32'h110);
        in_data[3*FW +: FW] = mk(0, 0, 0, 0, 32'h310);
        in_valid = 5'b01001;
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("rr_wrap_n", 64'(out_data[4*FW +: FW]), 64'(mk(0, 0, 0, 0, 32'h110)));
        tick();
        chk("rr_wrap_w", 64'(out_data[4*FW +: FW]), 64'(mk(0, 0, 0, 0, 32'h310)));
        tick();

        // backpressure on E
        fill_e(12, sent);
        chk("bp_accepted", 64'(sent), 5);
        chk("bp_ready_low", 64'(in_ready[4]), 0);
        chk("bp_out_held", {23'b0, out_valid[1], out_data[1*FW +: FW]},
            {23'b0, 1'b1, mk(0, 0, 0, 0, 32'hA0)});
        out_ready[1] = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (in_valid[4] && in_ready[4]) sent++;
            if (out_valid[1]) begin
                chk("bp_order", 64'(out_data[1*FW +: FW]), 64'(mk(0, 0, 0, 0, 32'hA0 + got)));
                got++;
            end
            tick();
            if (sent >= 6) in_valid[4] = 1'b0;
            else in_data[4*FW +: FW] = mk(0, 0, 3'b001, 3'b000, 32'hA0 + sent);
        end
        chk("bp_count", 64'(got), 6);
        tick();
        tick();
        chk("bp_no_dup", 64'(out_valid), 0);

        // U-turn on E alongside a normal N->L flit
        in_data[1*FW +: FW] = mk(0, 0, 3'b001, 3'b000, 32'hBAD);
        in_data[0*FW +: FW] = mk(0, 0, 0, 0, 32'h55);
        in_valid = 5'b00011;
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("ut_err_set", 64'(err_uturn), 1);
        chk("ut_other_ok", 64'(out_valid), 64'h10);
        chk("ut_other_data", 64'(out_data[4*FW +: FW]), 64'(mk(0, 0, 0, 0, 32'h55)));
        tick();
        tick();
        tick();
        chk("ut_dropped", 64'(out_valid), 0);
        chk("ut_err_sticky", 64'(err_uturn), 1);

        // reset in the middle of a backpressured transfer
        fill_e(8, sent);
        do_reset();
        tick();
        tick();
        tick();
        chk("mid_rst_lost", 64'(out_valid), 0);

        rand_phase();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
